// File: rtl/game_input_pkg.sv
// Shared types for the game input arbiter: command encoding and FSM states.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package game_input_pkg;

  // Commands listed in issue priority order (highest first after CMD_NONE).
  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_HOLD,
    CMD_DROP,
    CMD_ROT_CW,
    CMD_ROT_CCW,
    CMD_LEFT,
    CMD_RIGHT,
    CMD_DOWN
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } arb_state_e;

  // Pending vector layout: bit (cmd - 1), i.e. bit0 = hold ... bit6 = down.
  localparam int NUM_CMDS = 7;

  // Lowest set bit wins, which is the highest-priority command.
  function automatic cmd_e pick_cmd(input logic [NUM_CMDS-1:0] pend);
    cmd_e c;
    c = CMD_NONE;
    for (int i = NUM_CMDS - 1; i >= 0; i--) begin
      if (pend[i]) c = cmd_e'(3'(i + 1));
    end
    return c;
  endfunction

  function automatic logic [NUM_CMDS-1:0] cmd_mask(input cmd_e c);
    logic [NUM_CMDS-1:0] m;
    case (c)
      CMD_HOLD:    m = 7'b0000001;
      CMD_DROP:    m = 7'b0000010;
      CMD_ROT_CW:  m = 7'b0000100;
      CMD_ROT_CCW: m = 7'b0001000;
      CMD_LEFT:    m = 7'b0010000;
      CMD_RIGHT:   m = 7'b0100000;
      CMD_DOWN:    m = 7'b1000000;
      default:     m = 7'b0000000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/das_repeat.sv
// Per-key edge detect plus auto-repeat timer (first delay, then fixed period).
// Latency: key_event is combinational from lvl at the sampling edge (0 clk).
// Backpressure: none; events are fire-and-forget, the caller saturates them.
// Ports: clk, rst_n (sync, active low), tick_ms (1 ms strobe), lvl (held level),
//        first_ms / period_ms (tick counts), key_event (1-cycle event).
module das_repeat (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_ms,
  input  logic       lvl,
  input  logic [7:0] first_ms,
  input  logic [7:0] period_ms,
  output logic       key_event
);

  logic       prev;
  logic       armed;
  logic       live;     // key pressed after arming and still held
  logic       rpt;      // first delay elapsed, now in periodic phase
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic [7:0] limit;
  logic       rise;
  logic       hit;

  assign rise    = armed & lvl & ~prev;
  assign cnt_inc = cnt + 8'd1;
  assign limit   = rpt ? period_ms : first_ms;
  // A release in the same cycle as a tick suppresses the repeat (lvl term).
  assign hit       = live & lvl & tick_ms & (cnt_inc >= limit);
  assign key_event = rise | hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev  <= 1'b0;
      armed <= 1'b0;
      live  <= 1'b0;
      rpt   <= 1'b0;
      cnt   <= 8'd0;
    end else begin
      prev  <= lvl;
      armed <= 1'b1;
      if (!lvl) begin
        live <= 1'b0;
        rpt  <= 1'b0;
        cnt  <= 8'd0;
      end else if (rise) begin
        // A tick coinciding with the press is deliberately not counted.
        live <= 1'b1;
        rpt  <= 1'b0;
        cnt  <= 8'd0;
      end else if (live && tick_ms) begin
        if (hit) begin
          cnt <= 8'd0;
          rpt <= 1'b1;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: rtl/game_input_arbiter.sv
// Turns held key levels into paced single-cycle command pulses with DAS/ARR repeat.
// Latency: level rise to command pulse is 2 clk minimum (idle, cmd_ready high).
// Backpressure: cmd_ready low holds pending commands indefinitely; repeats saturate.
// Ports: clk, rst_n (sync, active low), tick_ms, cmd_ready, lvl_* (7 held levels),
//        key_* (7 command pulses, one-hot or zero), key_drop_held, cmd_busy.
// Build option: GAME_INPUT_LAST_WINS_EN -- with left+right held, the most recently
//        pressed direction wins instead of both cancelling.
module game_input_arbiter
  import game_input_pkg::*;
#(
  parameter int DAS_MS     = 170,
  parameter int ARR_MS     = 50,
  parameter int SDR_MS     = 33,
  parameter int GAP_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_ms,
  input  logic cmd_ready,
  input  logic lvl_left,
  input  logic lvl_right,
  input  logic lvl_down,
  input  logic lvl_rot_cw,
  input  logic lvl_rot_ccw,
  input  logic lvl_drop,
  input  logic lvl_hold,
  output logic key_left,
  output logic key_right,
  output logic key_down,
  output logic key_rotate_cw,
  output logic key_rotate_ccw,
  output logic key_drop,
  output logic key_hold,
  output logic key_drop_held,
  output logic cmd_busy
);

  // S_GAP lasts GAP_CYCLES-1 cycles; the S_IDLE cycle completes the gap.
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 2);

  arb_state_e          state, state_nxt;
  cmd_e                issue_cmd;
  logic [3:0]          gap_cnt;
  logic [NUM_CMDS-1:0] pending;
  logic [NUM_CMDS-1:0] ev;
  logic [NUM_CMDS-1:0] clr_mask;

  logic armed;
  logic prev_hold, prev_drop, prev_cw, prev_ccw;
  logic ev_hold, ev_drop, ev_cw, ev_ccw;
  logic lvl_left_g, lvl_right_g;
  logic ev_left_raw, ev_right_raw, ev_down;
  logic ev_left, ev_right;

  assign ev_hold = armed & lvl_hold    & ~prev_hold;
  assign ev_drop = armed & lvl_drop    & ~prev_drop;
  assign ev_cw   = armed & lvl_rot_cw  & ~prev_cw;
  assign ev_ccw  = armed & lvl_rot_ccw & ~prev_ccw;

`ifdef GAME_INPUT_LAST_WINS_EN
  logic prev_left, prev_right;
  logic last_right, last_right_nxt;
  logic rise_l, rise_r;

  assign rise_l = armed & lvl_left  & ~prev_left;
  assign rise_r = armed & lvl_right & ~prev_right;

  // Winner is resolved combinationally so the new press acts at its own edge.
  always_comb begin
    last_right_nxt = last_right;
    if (rise_l)      last_right_nxt = 1'b0;
    else if (rise_r) last_right_nxt = 1'b1;
  end

  // The loser sees a released level, so it restarts with a fresh DAS later.
  assign lvl_left_g  = lvl_left  & ~(lvl_right & last_right_nxt);
  assign lvl_right_g = lvl_right & ~(lvl_left  & ~last_right_nxt);
  assign ev_left     = ev_left_raw;
  assign ev_right    = ev_right_raw;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_left  <= 1'b0;
      prev_right <= 1'b0;
      last_right <= 1'b0;
    end else begin
      prev_left  <= lvl_left;
      prev_right <= lvl_right;
      last_right <= last_right_nxt;
    end
  end
`else
  assign lvl_left_g  = lvl_left;
  assign lvl_right_g = lvl_right;
  assign ev_left     = ev_left_raw  & ~(lvl_left & lvl_right);
  assign ev_right    = ev_right_raw & ~(lvl_left & lvl_right);
`endif

  das_repeat u_left (
    .clk(clk), .rst_n(rst_n), .tick_ms(tick_ms), .lvl(lvl_left_g),
    .first_ms(8'(DAS_MS)), .period_ms(8'(ARR_MS)), .key_event(ev_left_raw)
  );

  das_repeat u_right (
    .clk(clk), .rst_n(rst_n), .tick_ms(tick_ms), .lvl(lvl_right_g),
    .first_ms(8'(DAS_MS)), .period_ms(8'(ARR_MS)), .key_event(ev_right_raw)
  );

  das_repeat u_down (
    .clk(clk), .rst_n(rst_n), .tick_ms(tick_ms), .lvl(lvl_down),
    .first_ms(8'(SDR_MS)), .period_ms(8'(SDR_MS)), .key_event(ev_down)
  );

  assign ev       = {ev_down, ev_right, ev_left, ev_ccw, ev_cw, ev_drop, ev_hold};
  assign clr_mask = (state == S_ISSUE) ? cmd_mask(issue_cmd) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    cmd_busy       = (state != S_IDLE);
    key_hold       = 1'b0;
    key_drop       = 1'b0;
    key_rotate_cw  = 1'b0;
    key_rotate_ccw = 1'b0;
    key_left       = 1'b0;
    key_right      = 1'b0;
    key_down       = 1'b0;
    case (state)
      S_IDLE:  if ((|pending) && cmd_ready) state_nxt = S_ISSUE;
      S_ISSUE: begin
        state_nxt = S_GAP;
        case (issue_cmd)
          CMD_HOLD:    key_hold       = 1'b1;
          CMD_DROP:    key_drop       = 1'b1;
          CMD_ROT_CW:  key_rotate_cw  = 1'b1;
          CMD_ROT_CCW: key_rotate_ccw = 1'b1;
          CMD_LEFT:    key_left       = 1'b1;
          CMD_RIGHT:   key_right      = 1'b1;
          CMD_DOWN:    key_down       = 1'b1;
          default: ;
        endcase
      end
      S_GAP:   if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_cmd <= CMD_NONE;
      gap_cnt   <= 4'd0;
      pending   <= '0;
      armed     <= 1'b0;
      prev_hold <= 1'b0;
      prev_drop <= 1'b0;
      prev_cw   <= 1'b0;
      prev_ccw  <= 1'b0;
    end else begin
      armed     <= 1'b1;
      prev_hold <= lvl_hold;
      prev_drop <= lvl_drop;
      prev_cw   <= lvl_rot_cw;
      prev_ccw  <= lvl_rot_ccw;
      if (state == S_IDLE && state_nxt == S_ISSUE) issue_cmd <= pick_cmd(pending);
      gap_cnt <= (state == S_GAP) ? gap_cnt + 4'd1 : 4'd0;
      // A new event for the command being issued survives the clear.
      pending <= (pending & ~clr_mask) | ev;
    end
  end

  assign key_drop_held = prev_drop;

endmodule

// File: tb/tb_game_input_arbiter.sv
// Directed bench for game_input_arbiter: per-cycle vector table plus corner sequences.
// Latency: n/a.
// Backpressure: cmd_ready driven directly by the stimulus.
module tb_game_input_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_ms = 1'b0;
  logic       cmd_ready = 1'b1;
  logic [6:0] lvl_v = 7'h00;   // bit0 hold,1 drop,2 cw,3 ccw,4 left,5 right,6 down
  logic [6:0] outs;
  logic       key_left, key_right, key_down, key_rotate_cw, key_rotate_ccw;
  logic       key_drop, key_hold, key_drop_held, cmd_busy;

  int compared = 0;
  int failed   = 0;
  int cyc      = 0;
  int oh_viol  = 0;
  int pcnt[7]  = '{default: 0};
  int plast[7] = '{default: 0};
  int tph      = 0;

  game_input_arbiter #(.DAS_MS(3), .ARR_MS(2), .SDR_MS(2), .GAP_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .tick_ms(tick_ms), .cmd_ready(cmd_ready),
    .lvl_left(lvl_v[4]), .lvl_right(lvl_v[5]), .lvl_down(lvl_v[6]),
    .lvl_rot_cw(lvl_v[2]), .lvl_rot_ccw(lvl_v[3]), .lvl_drop(lvl_v[1]),
    .lvl_hold(lvl_v[0]),
    .key_left(key_left), .key_right(key_right), .key_down(key_down),
    .key_rotate_cw(key_rotate_cw), .key_rotate_ccw(key_rotate_ccw),
    .key_drop(key_drop), .key_hold(key_hold),
    .key_drop_held(key_drop_held), .cmd_busy(cmd_busy)
  );

  assign outs = {key_down, key_right, key_left, key_rotate_ccw, key_rotate_cw, key_drop, key_hold};

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // 1 ms strobe every 10 clk.
  initial forever begin
    @(posedge clk); #1;
    tph = (tph == 9) ? 0 : tph + 1;
    tick_ms = (tph == 9);
  end

  // Pulse recorder, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if ($countones(outs) > 1) oh_viol++;
    for (int i = 0; i < 7; i++) begin
      if (outs[i] === 1'b1) begin
        pcnt[i]++;
        plast[i] = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [6:0] lvl;
    logic       rdy;
    logic [6:0] exp_out;
    logic       exp_busy;
    logic       exp_dh;
  } vec_t;

  vec_t tbl[19];
  int   base[7];
  int   t0;
  int   sum0;
  bit   found;

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int i = 0; i < 7; i++) base[i] = pcnt[i];
  endtask

  function automatic int total();
    int s;
    s = 0;
    for (int i = 0; i < 7; i++) s += pcnt[i];
    return s;
  endfunction

  initial begin
    //                 lvl    rdy   out    busy  dh
    tbl[0]  = '{7'h05, 1'b1, 7'h00, 1'b0, 1'b0};
    tbl[1]  = '{7'h05, 1'b1, 7'h00, 1'b0, 1'b0};
    tbl[2]  = '{7'h05, 1'b1, 7'h01, 1'b1, 1'b0};
    tbl[3]  = '{7'h05, 1'b1, 7'h00, 1'b1, 1'b0};
    tbl[4]  = '{7'h00, 1'b1, 7'h00, 1'b1, 1'b0};
    tbl[5]  = '{7'h00, 1'b1, 7'h00, 1'b1, 1'b0};
    tbl[6]  = '{7'h00, 1'b1, 7'h00, 1'b0, 1'b0};
    tbl[7]  = '{7'h00, 1'b1, 7'h04, 1'b1, 1'b0};
    tbl[8]  = '{7'h00, 1'b1, 7'h00, 1'b1, 1'b0};
    tbl[9]  = '{7'h00, 1'b1, 7'h00, 1'b1, 1'b0};
    tbl[10] = '{7'h00, 1'b1, 7'h00, 1'b1, 1'b0};
    tbl[11] = '{7'h00, 1'b1, 7'h00, 1'b0, 1'b0};
    tbl[12] = '{7'h02, 1'b1, 7'h00, 1'b0, 1'b0};
    tbl[13] = '{7'h02, 1'b1, 7'h00, 1'b0, 1'b1};
    tbl[14] = '{7'h02, 1'b1, 7'h02, 1'b1, 1'b1};
    tbl[15] = '{7'h00, 1'b1, 7'h00, 1'b1, 1'b1};
    tbl[16] = '{7'h00, 1'b1, 7'h00, 1'b1, 1'b0};
    tbl[17] = '{7'h00, 1'b1, 7'h00, 1'b1, 1'b0};
    tbl[18] = '{7'h00, 1'b1, 7'h00, 1'b0, 1'b0};

    // Reset with hold already pressed.
    rst_n = 1'b0; lvl_v = 7'h01; cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", int'(outs), 0);
    chk("reset_busy", int'(cmd_busy), 0);
    chk("reset_drop_held", int'(key_drop_held), 0);
    step(1);
    rst_n = 1'b1;

    // Key held through reset must stay silent until re-pressed.
    step(30);
    chk("held_through_reset_no_hold", pcnt[0], 0);
    lvl_v = 7'h00;
    step(3);
    snap();
    lvl_v = 7'h01; t0 = cyc;
    step(10);
    chk("repress_hold_count", pcnt[0] - base[0], 1);
    chk("repress_hold_latency", plast[0] - t0, 2);
    lvl_v = 7'h00;
    step(10);

    // Cycle-accurate table: simultaneous hold+rot_cw, then a drop press.
    for (int i = 0; i < 19; i++) begin
      step(1);
      lvl_v = tbl[i].lvl;
      cmd_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_outs", i), int'(outs), int'(tbl[i].exp_out));
      chk($sformatf("tbl%0d_busy", i), int'(cmd_busy), int'(tbl[i].exp_busy));
      chk($sformatf("tbl%0d_drop_held", i), int'(key_drop_held), int'(tbl[i].exp_dh));
    end
    step(5);

    // Left held 100 clk: immediate, DAS at tick 3, then ticks 5,7,9.
    snap();
    lvl_v = 7'h10; t0 = cyc;
    step(3);
    chk("left_first_count", pcnt[4] - base[4], 1);
    chk("left_first_latency", plast[4] - t0, 2);
    step(97);
    lvl_v = 7'h00;
    step(20);
    chk("left_repeat_total", pcnt[4] - base[4], 5);
    chk("left_hold_no_right", pcnt[5] - base[5], 0);

    // Backpressure: commands wait, saturate, then drain in priority order.
    cmd_ready = 1'b0;
    snap();
    sum0 = total();
    lvl_v = 7'h02; step(1); lvl_v = 7'h00; step(1);
    lvl_v = 7'h08; step(1); lvl_v = 7'h00; step(1);
    lvl_v = 7'h40; step(1); lvl_v = 7'h00; step(1);
    lvl_v = 7'h40; step(1); lvl_v = 7'h00; step(20);
    chk("stalled_no_pulses", total() - sum0, 0);
    cmd_ready = 1'b1; t0 = cyc;
    step(30);
    chk("drain_drop_count", pcnt[1] - base[1], 1);
    chk("drain_ccw_count", pcnt[3] - base[3], 1);
    chk("drain_down_count", pcnt[6] - base[6], 1);
    chk("drain_drop_latency", plast[1] - t0, 1);
    chk("drain_ccw_spacing", plast[3] - plast[1], 5);
    chk("drain_down_spacing", plast[6] - plast[3], 5);

    // Reset during the gap with three commands still pending.
    cmd_ready = 1'b0;
    lvl_v = 7'h0F; step(1); lvl_v = 7'h00; step(3);
    t0 = pcnt[0];
    cmd_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk); #1;
      if (pcnt[0] != t0) found = 1'b1;
    end
    chk("gap_reset_hold_issued", int'(found), 1);
    step(1);
    @(negedge clk);
    chk("gap_reset_busy_before", int'(cmd_busy), 1);
    step(1);
    rst_n = 1'b0;
    step(3);
    @(negedge clk);
    chk("gap_reset_outs_in_reset", int'(outs), 0);
    chk("gap_reset_busy_in_reset", int'(cmd_busy), 0);
    sum0 = total();
    step(1);
    rst_n = 1'b1;
    step(30);
    @(negedge clk);
    chk("gap_reset_no_pulses", total() - sum0, 0);
    chk("gap_reset_busy_after", int'(cmd_busy), 0);
    chk("gap_reset_drop_held", int'(key_drop_held), 0);
    step(2);

    // Left held, then right added.
    snap();
    lvl_v = 7'h10;
    step(10);
    chk("lr_left_alone", pcnt[4] - base[4], 1);
    snap();
    lvl_v = 7'h30;
    step(60);
    lvl_v = 7'h00;
    step(10);
    chk("lr_left_suppressed", pcnt[4] - base[4], 0);
`ifdef GAME_INPUT_LAST_WINS_EN
    chk("lr_right_wins", pcnt[5] - base[5], 3);
`else
    chk("lr_right_cancelled", pcnt[5] - base[5], 0);
`endif

    chk("one_hot_violations", oh_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
